// File: rtl/input_range_normalizer.sv
// Two-stage normaliser: measures redundant sign bits, left-shifts the sample as far as
// precision allows (in SHIFT_STEP units), then rounds to an OUT_WIDTH operand.
module input_range_normalizer #(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 12,
    parameter int SHIFT_STEP = 1,
    parameter int ROUND_EN   = 1,
    parameter int CNT_WIDTH  = 16,
    localparam int MAX_SHIFT = IN_WIDTH - OUT_WIDTH,
    localparam int SW        = $clog2(MAX_SHIFT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [SW-1:0]        out_shift,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] full_shift_cnt
);

    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    // A transfer happens on any rising edge where valid and ready are both high;
    // each stage advances when it is empty or its consumer advances.
    logic adv1;
    logic adv2;

    logic                s1_valid;
    logic [IN_WIDTH-1:0] s1_data;
    logic [SW-1:0]       s1_shift;

    logic [SW-1:0] in_shift;
    int            run_len;
    int            shift_int;
    logic          run;

    logic [OUT_WIDTH:0]    top_bits;
    logic [OUT_WIDTH-1:0]  mant;
    logic                  guard;
    logic [OUT_WIDTH-1:0]  rounded;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    // Redundant sign run, clamped to MAX_SHIFT and floored to the shift granularity.
    always_comb begin
        run       = 1'b1;
        run_len   = 0;
        shift_int = 0;
        for (int i = IN_WIDTH - 2; i >= 0; i--) begin
            if (run && (in_data[i] == in_data[IN_WIDTH-1])) begin
                run_len = run_len + 1;
            end else begin
                run = 1'b0;
            end
        end
        shift_int = (run_len > MAX_SHIFT) ? MAX_SHIFT : run_len;
        shift_int = (shift_int / SHIFT_STEP) * SHIFT_STEP;
        in_shift  = SW'(shift_int);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data  <= in_data;
                s1_shift <= in_shift;
            end
        end
    end

    // Keep only the operand bits plus the first discarded bit of the shifted sample.
    always_comb begin
        top_bits = (OUT_WIDTH+1)'((s1_data << s1_shift) >> (MAX_SHIFT - 1));
        mant     = top_bits[OUT_WIDTH:1];
        guard    = top_bits[0];
        rounded  = mant;
        if ((ROUND_EN != 0) && guard && (mant != MAX_POS)) begin
            rounded = mant + OUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shift <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= rounded;
                out_shift <= s1_shift;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_shift_cnt <= '0;
        end else if (cnt_clear) begin
            full_shift_cnt <= '0;
        end else if (out_valid && out_ready && (out_shift == SW'(MAX_SHIFT))
                     && (full_shift_cnt != {CNT_WIDTH{1'b1}})) begin
            full_shift_cnt <= full_shift_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
